// File: rtl/demux_1x2_stream_if.sv
// demux_1x2_stream_if
// Stream bundle for the 1-to-2 demux: one input beat channel with routing
// controls, two FWFT output lanes with their occupancy levels.
//   master : drives s/mode/sync/d/d_valid and the lane readies (upstream + sinks)
//   slave  : the demux itself; drives d_ready, lane data/valid and levels
interface demux_1x2_stream_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             s;
    logic             mode;
    logic             sync;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] o0;
    logic [WIDTH-1:0] o1;
    logic             o0_valid;
    logic             o1_valid;
    logic             o0_ready;
    logic             o1_ready;
    logic [LW-1:0]    lvl0;
    logic [LW-1:0]    lvl1;

    modport master (
        output s, mode, sync, d, d_valid, o0_ready, o1_ready,
        input  d_ready, o0, o1, o0_valid, o1_valid, lvl0, lvl1
    );

    modport slave (
        input  s, mode, sync, d, d_valid, o0_ready, o1_ready,
        output d_ready, o0, o1, o0_valid, o1_valid, lvl0, lvl1
    );
endinterface

// File: rtl/demux_1x2_stream.sv
// demux_1x2_stream
// Routes an input beat stream to one of two lanes, each buffered in a
// first-word-fall-through FIFO of DEPTH entries. Lane choice is either manual
// (by s) or alternating (internal phase bit, restartable by sync).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : demux_1x2_stream_if.slave (input beat, routing controls,
//           two output lanes with levels)

// Per-lane FWFT FIFO. The caller never pushes into a full lane, so there is
// no overflow guard here.
module demux_lane_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    output logic [LW-1:0]    lvl
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    lvl_q;
    logic             pop;

    assign dvalid = (lvl_q != '0);
    assign pop    = dvalid & pop_rdy;
    assign lvl    = lvl_q;
    // Stale storage is never exposed: the head reads zero while empty.
    assign dout   = dvalid ? mem[rd_ptr] : '0;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   lvl_q <= lvl_q + LW'(1);
                2'b01:   lvl_q <= lvl_q - LW'(1);
                default: lvl_q <= lvl_q;
            endcase
        end
    end

    // Storage is not reset; contents are masked by dvalid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

module demux_1x2_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    demux_1x2_stream_if.slave  bus
);
    localparam int NUM_LANES = 2;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic                                phase_q;
    logic                                tgt;
    logic                                accept;
    logic [NUM_LANES-1:0]                push;
    logic [NUM_LANES-1:0]                out_rdy;
    logic [NUM_LANES-1:0]                out_vld;
    logic [NUM_LANES-1:0][WIDTH-1:0]     out_dat;
    logic [NUM_LANES-1:0][LW-1:0]        lvl;

    // sync pins the current beat to lane 0 regardless of phase.
    always_comb begin
        tgt = bus.s;
        if (bus.mode) tgt = bus.sync ? 1'b0 : phase_q;
    end

    // Strict less-than: a full lane refuses even if it pops this cycle.
    // rst_n is folded in so d_ready drops immediately on reset assertion.
    assign bus.d_ready = rst_n && (lvl[tgt] < LW'(DEPTH));
    assign accept      = bus.d_valid & bus.d_ready;
    assign out_rdy     = {bus.o1_ready, bus.o0_ready};

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            assign push[i] = accept && (tgt == 1'(i));

            demux_lane_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .push    (push[i]),
                .din     (bus.d),
                .pop_rdy (out_rdy[i]),
                .dout    (out_dat[i]),
                .dvalid  (out_vld[i]),
                .lvl     (lvl[i])
            );
        end
    endgenerate

    // sync restarts alternation: after a synced accept (which went to lane 0)
    // the next beat goes to lane 1; with no accept, alternation restarts at 0.
    // sync acts in manual mode too, which is the only way phase moves there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
        end else if (bus.sync) begin
            phase_q <= accept;
        end else if (bus.mode && accept) begin
            phase_q <= ~tgt;
        end
    end

    assign bus.o0       = out_dat[0];
    assign bus.o1       = out_dat[1];
    assign bus.o0_valid = out_vld[0];
    assign bus.o1_valid = out_vld[1];
    assign bus.lvl0     = lvl[0];
    assign bus.lvl1     = lvl[1];
endmodule

// File: tb/tb_demux_1x2_stream.sv
// tb_demux_1x2_stream
// Randomized and directed stimulus against a queue-based reference model.
module tb_demux_1x2_stream;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    demux_1x2_stream_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    demux_1x2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: one queue per lane plus the alternation phase
    int q0[$];
    int q1[$];
    bit ph;
    int got0[$];
    int got1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drv(input bit s_, input bit m_, input bit sy_, input int d_,
                       input bit dv_, input bit r0_, input bit r1_);
        bus.s        = s_;
        bus.mode     = m_;
        bus.sync     = sy_;
        bus.d        = d_[WIDTH-1:0];
        bus.d_valid  = dv_;
        bus.o0_ready = r0_;
        bus.o1_ready = r1_;
    endtask

    function automatic bit model_tgt();
        if (!bus.mode) return bus.s;
        if (bus.sync) return 1'b0;
        return ph;
    endfunction

    task automatic check_outputs();
        bit t;
        int lv;
        t  = model_tgt();
        lv = t ? q1.size() : q0.size();
        chk("d_ready",  bus.d_ready,  lv < DEPTH);
        chk("lvl0",     bus.lvl0,     q0.size());
        chk("lvl1",     bus.lvl1,     q1.size());
        chk("o0_valid", bus.o0_valid, q0.size() != 0);
        chk("o1_valid", bus.o1_valid, q1.size() != 0);
        chk("o0",       bus.o0,       (q0.size() != 0) ? q0[0] : 0);
        chk("o1",       bus.o1,       (q1.size() != 0) ? q1[0] : 0);
    endtask

    // Called at a falling edge with inputs already driven; returns at the
    // next falling edge with the model advanced across the rising edge.
    task automatic step();
        bit t, acc, p0, p1, sy, md;
        int dd;
        #1;
        check_outputs();
        t   = model_tgt();
        acc = bus.d_valid && ((t ? q1.size() : q0.size()) < DEPTH);
        p0  = (q0.size() != 0) && bus.o0_ready;
        p1  = (q1.size() != 0) && bus.o1_ready;
        sy  = bus.sync;
        md  = bus.mode;
        dd  = int'(bus.d);
        if (bus.o0_valid && bus.o0_ready) got0.push_back(int'(bus.o0));
        if (bus.o1_valid && bus.o1_ready) got1.push_back(int'(bus.o1));
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (t) q1.push_back(dd);
            else   q0.push_back(dd);
        end
        if (sy)             ph = acc;
        else if (md && acc) ph = !t;
        @(negedge clk);
    endtask

    task automatic drain();
        drv(0, 0, 0, 0, 0, 1, 1);
        repeat (DEPTH + 1) step();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases at the
    // following falling edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_lvl0",     bus.lvl0,     0);
        chk("rst_lvl1",     bus.lvl1,     0);
        chk("rst_o0_valid", bus.o0_valid, 0);
        chk("rst_o1_valid", bus.o1_valid, 0);
        chk("rst_o0",       bus.o0,       0);
        chk("rst_o1",       bus.o1,       0);
        chk("rst_d_ready",  bus.d_ready,  0);
        q0.delete();
        q1.delete();
        ph = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        ph    = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("init_lvl0",    bus.lvl0,    0);
        chk("init_d_ready", bus.d_ready, 0);
        rst_n = 1'b1;

        // reset with three beats buffered in lane 0
        for (int k = 0; k < 3; k++) begin
            drv(0, 0, 0, 'h20 + k, 1, 0, 0);
            step();
        end
        chk("pre_rst_lvl0", bus.lvl0, 3);
        do_reset();
        drv(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post_rst_d_ready", bus.d_ready, 1);
        step();

        // manual routing
        drv(0, 0, 0, 'hA1, 1, 0, 0);
        step();
        chk("man_o0",       bus.o0,       'hA1);
        chk("man_o0_valid", bus.o0_valid, 1);
        drv(1, 0, 0, 'hB2, 1, 0, 0);
        step();
        chk("man_o1",   bus.o1,   'hB2);
        chk("man_lvl0", bus.lvl0, 1);
        chk("man_lvl1", bus.lvl1, 1);
        drain();

        // alternate mode, sync on the first beat
        got0.delete();
        got1.delete();
        drv(0, 1, 1, 'h10, 1, 1, 1);
        step();
        for (int k = 1; k < 6; k++) begin
            drv(0, 1, 0, 'h10 + k, 1, 1, 1);
            step();
        end
        drain();
        chk("alt_n0", got0.size(), 3);
        chk("alt_n1", got1.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < got0.size()) chk("alt_o0_seq", got0[k], 'h10 + 2 * k);
            if (k < got1.size()) chk("alt_o1_seq", got1[k], 'h11 + 2 * k);
        end

        // backpressure on lane 0
        for (int k = 0; k < 5; k++) begin
            drv(0, 0, 0, 'h30 + k, 1, 0, 1);
            step();
        end
        chk("bp_lvl0",    bus.lvl0,    4);
        chk("bp_d_ready", bus.d_ready, 0);
        drv(1, 0, 0, 0, 0, 0, 1);
        #1;
        chk("bp_d_ready_s1", bus.d_ready, 1);
        got0.delete();
        drv(0, 0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_lvl0_dec", bus.lvl0, 3 - k);
        end
        chk("bp_n0", got0.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < got0.size()) chk("bp_seq", got0[k], 'h30 + k);

        // simultaneous push and pop on lane 1
        drv(1, 0, 0, 'h61, 1, 0, 0);
        step();
        drv(1, 0, 0, 'h62, 1, 0, 0);
        step();
        chk("sim_lvl1_pre", bus.lvl1, 2);
        drv(1, 0, 0, 'h63, 1, 0, 1);
        #1;
        chk("sim_pop_val", bus.o1, 'h61);
        step();
        chk("sim_lvl1", bus.lvl1, 2);
        chk("sim_head", bus.o1,   'h62);
        drain();

        // sync mid-stream with phase already 1
        drv(0, 1, 1, 'h40, 1, 0, 0);
        step();
        drv(0, 1, 1, 'h55, 1, 0, 0);
        step();
        drv(0, 1, 0, 'h56, 1, 0, 0);
        step();
        chk("sync_lvl0", bus.lvl0, 2);
        chk("sync_lvl1", bus.lvl1, 1);
        chk("sync_o1",   bus.o1,   'h56);
        drain();

        // random traffic with occasional reset
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(149) == 0) begin
                do_reset();
            end else begin
                drv($urandom_range(1), $urandom_range(1), $urandom_range(7) == 0,
                    $urandom_range(255), $urandom_range(3) != 0,
                    $urandom_range(1), $urandom_range(1));
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
